axis_const_multiplier: RTL and testbench



---
 rtl/axis_mult_pkg.sv | 44 ++++
 rtl/axis_const_multiplier_if.sv | 25 ++
 rtl/axis_pipe_reg.sv | 32 +++
 rtl/axis_const_multiplier.sv | 103 ++++++++++
 tb/tb_axis_const_multiplier.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_mult_pkg.sv
// Shared widths, stage bundles and the multiply helper
// for the stream constant multiplier.
package axis_mult_pkg;

  localparam int DATA_W  = 32;
  localparam int CONST_W = 8;
  localparam int PROD_W  = DATA_W + CONST_W;

  localparam logic [DATA_W-1:0] SAT_VAL = '1;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               last;
    logic [CONST_W-1:0] op_const;
    logic               op_en;
  } s1_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } s2_t;

  // Returns {overflow, result}
  function automatic logic [DATA_W:0] mult_op(
    input logic [DATA_W-1:0]  d,
    input logic [CONST_W-1:0] k,
    input logic               en,
    input bit                 sat
  );
    logic [PROD_W-1:0] p;
    logic              hi;
    logic [DATA_W-1:0] r;
    p  = PROD_W'(d) * PROD_W'(k);
    hi = en && (p[PROD_W-1:DATA_W] != '0);
    if (!en)
      r = d;
    else if (hi && sat)
      r = SAT_VAL;
    else
      r = p[DATA_W-1:0];
    return {hi, r};
  endfunction

endpackage

// File: rtl/axis_const_multiplier_if.sv
// AXI4-Stream bundle: data, last and the
// valid/ready pair.
interface axis_const_multiplier_if;
  import axis_mult_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_pipe_reg.sv
// Single valid/ready register slice; accepts a new
// word whenever it is empty or being drained.
module axis_pipe_reg #(
  parameter int W = 1
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic load;

  assign load     = !out_valid || out_ready;
  assign in_ready = load;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid)
        out_data <= in_data;
    end
  end

endmodule

// File: rtl/axis_const_multiplier.sv
// Two-stage stream multiplier; en/mult_const are
// frozen for the duration of each input frame.
module axis_const_multiplier
  import axis_mult_pkg::*;
#(
  parameter bit C_SATURATE = 1'b0,
  parameter int C_CNT_BITS = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axis_const_multiplier_if.slave  s_axis,
  axis_const_multiplier_if.master m_axis,
  input  logic                   en,
  input  logic [CONST_W-1:0]     mult_const,
  output logic                   ovf,
  output logic                   frame_done,
  output logic [C_CNT_BITS-1:0]  frame_cnt
);

  s1_t s1_in;
  s1_t s1_q;
  s2_t s2_in;
  s2_t s2_q;

  logic               v1;
  logic               s1_rdy;
  logic               s2_rdy;
  logic               in_beat;
  logic               xfer12;
  logic               m_done;
  logic               in_frame;
  logic               fr_en;
  logic [CONST_W-1:0] fr_const;
  logic [DATA_W:0]    op_res;

  assign s_axis.tready = s1_rdy;
  assign in_beat = s_axis.tvalid && s1_rdy;

  // First beat of a frame uses the live controls
  assign s1_in = '{
    data:     s_axis.tdata,
    last:     s_axis.tlast,
    op_const: in_frame ? fr_const : mult_const,
    op_en:    in_frame ? fr_en : en
  };

  axis_pipe_reg #(.W($bits(s1_t))) u_s1 (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (s_axis.tvalid),
    .in_data   (s1_in),
    .in_ready  (s1_rdy),
    .out_valid (v1),
    .out_data  (s1_q),
    .out_ready (s2_rdy)
  );

  assign op_res = mult_op(s1_q.data, s1_q.op_const,
                          s1_q.op_en, C_SATURATE);
  assign s2_in  = '{data: op_res[DATA_W-1:0], last: s1_q.last};
  assign xfer12 = v1 && s2_rdy;

  axis_pipe_reg #(.W($bits(s2_t))) u_s2 (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (v1),
    .in_data   (s2_in),
    .in_ready  (s2_rdy),
    .out_valid (m_axis.tvalid),
    .out_data  (s2_q),
    .out_ready (m_axis.tready)
  );

  assign m_axis.tdata = s2_q.data;
  assign m_axis.tlast = s2_q.last;

  assign m_done = m_axis.tvalid && m_axis.tready && m_axis.tlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_frame   <= 1'b0;
      fr_en      <= 1'b0;
      fr_const   <= '0;
      ovf        <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (in_beat) begin
        if (!in_frame) begin
          fr_en    <= en;
          fr_const <= mult_const;
        end
        in_frame <= !s_axis.tlast;
      end
      if (xfer12 && op_res[DATA_W])
        ovf <= 1'b1;
      frame_done <= m_done;
      if (m_done)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_const_multiplier.sv
// Bench: vector table, directed frame sequences and
// random traffic against a scoreboard model.
module tb_axis_const_multiplier;
  import axis_mult_pkg::*;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        mready;
  logic        en;
  logic [7:0]  k;

  axis_const_multiplier_if s0 ();
  axis_const_multiplier_if s1 ();
  axis_const_multiplier_if m0 ();
  axis_const_multiplier_if m1 ();

  assign s0.tdata  = tdata;
  assign s0.tvalid = tvalid;
  assign s0.tlast  = tlast;
  assign s1.tdata  = tdata;
  assign s1.tvalid = tvalid;
  assign s1.tlast  = tlast;
  assign m0.tready = mready;
  assign m1.tready = mready;

  logic        ovf0, ovf1, fd0, fd1;
  logic [15:0] fc0, fc1;

  axis_const_multiplier #(.C_SATURATE(1'b0), .C_CNT_BITS(16)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s0), .m_axis(m0),
    .en(en), .mult_const(k), .ovf(ovf0),
    .frame_done(fd0), .frame_cnt(fc0)
  );

  axis_const_multiplier #(.C_SATURATE(1'b1), .C_CNT_BITS(16)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s1), .m_axis(m1),
    .en(en), .mult_const(k), .ovf(ovf1),
    .frame_done(fd1), .frame_cnt(fc1)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_mul(
    input logic [31:0] d, input logic [7:0] kk,
    input logic e, input bit sat, output bit o);
    longint unsigned p;
    p = 64'(d) * 64'(kk);
    o = e && (p > 64'h0000_0000_FFFF_FFFF);
    if (!e) return d;
    if (o && sat) return 32'hFFFF_FFFF;
    return p[31:0];
  endfunction

  typedef struct {
    logic [31:0] d;
    logic        l;
    bit          o;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] oq0[$];
  logic [31:0] oq1[$];
  logic        ol0[$];
  int          ocyc0[$];
  int          icyc[$];

  bit          m_in_frame;
  logic        m_en;
  logic [7:0]  m_k;
  bit          eovf0, eovf1, prev_last;
  int          efr;
  int          done_cnt = 0;
  int          cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    exp_t       e;
    bit         o;
    logic       le;
    logic [7:0] lk;
    if (!aresetn) begin
      q0.delete();
      q1.delete();
      m_in_frame = 0;
      eovf0 = 0;
      eovf1 = 0;
      efr = 0;
      prev_last = 0;
    end else begin
      chk("frame_done0", 64'(fd0), 64'(prev_last));
      chk("frame_done1", 64'(fd1), 64'(prev_last));
      if (fd0) done_cnt++;
      prev_last = m0.tvalid && mready && m0.tlast;
      if (prev_last) efr++;
      if (s0.tvalid && s0.tready) begin
        le = m_in_frame ? m_en : en;
        lk = m_in_frame ? m_k : k;
        if (!m_in_frame) begin
          m_en = en;
          m_k = k;
        end
        m_in_frame = !tlast;
        e.d = ref_mul(tdata, lk, le, 1'b0, o);
        e.l = tlast;
        e.o = o;
        q0.push_back(e);
        e.d = ref_mul(tdata, lk, le, 1'b1, o);
        q1.push_back(e);
        icyc.push_back(cyc);
      end
      if (m0.tvalid && mready) begin
        if (q0.size() == 0) begin
          chk("unexpected_out0", 64'(m0.tdata), 64'hX);
        end else begin
          e = q0.pop_front();
          chk("out0_data", 64'(m0.tdata), 64'(e.d));
          chk("out0_last", 64'(m0.tlast), 64'(e.l));
          if (e.o) eovf0 = 1;
        end
        oq0.push_back(m0.tdata);
        ol0.push_back(m0.tlast);
        ocyc0.push_back(cyc);
      end
      if (m1.tvalid && mready) begin
        if (q1.size() == 0) begin
          chk("unexpected_out1", 64'(m1.tdata), 64'hX);
        end else begin
          e = q1.pop_front();
          chk("out1_data", 64'(m1.tdata), 64'(e.d));
          chk("out1_last", 64'(m1.tlast), 64'(e.l));
          if (e.o) eovf1 = 1;
        end
        oq1.push_back(m1.tdata);
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    int n = 0;
    tdata = d;
    tlast = l;
    tvalid = 1'b1;
    while (n < 200) begin
      @(negedge aclk);
      if (s0.tready) break;
      n++;
    end
    if (n >= 200) chk("s_tready_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1;
    tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("drain_timeout", 64'(n < 300), 64'd1);
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    tvalid = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic chk_seq(input string nm, input int base,
                         input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] v3,
                         input int cnt);
    logic [31:0] ex[4];
    ex = '{v0, v1, v2, v3};
    chk({nm, "_count"}, 64'(oq0.size() - base), 64'(cnt));
    for (int i = 0; i < cnt; i++)
      if (base + i < oq0.size())
        chk({nm, "_data"}, 64'(oq0[base + i]), 64'(ex[i]));
  endtask

  typedef struct {
    logic [31:0] d;
    logic [7:0]  kk;
    logic        e;
    logic [31:0] x0;
    logic [31:0] x1;
    logic        ov;
  } vec_t;

  vec_t vt[6];
  int   base, ib, fb;
  logic [31:0] held;
  bit   seen, rdone;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'hDEAD_BEEF, 8'h07, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vt[1] = '{32'h0000_1234, 8'h00, 1'b1, 32'h0, 32'h0, 1'b0};
    vt[2] = '{32'h0000_0005, 8'h03, 1'b1, 32'd15, 32'd15, 1'b0};
    vt[3] = '{32'hFFFF_FFFF, 8'h01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vt[4] = '{32'h0200_0000, 8'hFF, 1'b1, 32'hFE00_0000, 32'hFFFF_FFFF, 1'b1};
    vt[5] = '{32'hFFFF_FFFF, 8'h02, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1};

    tdata = '0;
    tvalid = 1'b0;
    tlast = 1'b0;
    mready = 1'b1;
    en = 1'b1;
    k = 8'd3;
    do_reset();

    chk("rst_s_tready", 64'(s0.tready), 64'd1);
    chk("rst_m_tvalid", 64'(m0.tvalid), 64'd0);
    chk("rst_m_tdata", 64'(m0.tdata), 64'd0);
    chk("rst_m_tlast", 64'(m0.tlast), 64'd0);
    chk("rst_ovf", 64'(ovf0), 64'd0);
    chk("rst_frame_done", 64'(fd0), 64'd0);
    chk("rst_frame_cnt", 64'(fc0), 64'd0);

    // Basic 4-beat frame, x3
    base = oq0.size();
    ib = icyc.size();
    fb = done_cnt;
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b0);
    send_beat(32'd4, 1'b1);
    drain();
    chk_seq("t1", base, 32'd3, 32'd6, 32'd9, 32'd12, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < ol0.size())
        chk("t1_last", 64'(ol0[base + i]), 64'(i == 3));
    if (base < ocyc0.size())
      chk("t1_latency", 64'(ocyc0[base] - icyc[ib]), 64'd2);
    chk("t1_done_pulses", 64'(done_cnt - fb), 64'd1);
    chk("t1_frame_cnt", 64'(fc0), 64'd1);

    // Constant change mid-frame is ignored until next frame
    base = oq0.size();
    k = 8'd3;
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    k = 8'd5;
    send_beat(32'd3, 1'b0);
    send_beat(32'd4, 1'b1);
    drain();
    chk_seq("t2a", base, 32'd3, 32'd6, 32'd9, 32'd12, 4);
    base = oq0.size();
    send_beat(32'd1, 1'b0);
    send_beat(32'd1, 1'b1);
    drain();
    chk_seq("t2b", base, 32'd5, 32'd5, 32'd0, 32'd0, 2);
    chk("t2_frame_cnt", 64'(fc0), 64'd3);

    // Single-beat frame vector table, wrap and saturate
    foreach (vt[i]) begin
      base = oq0.size();
      en = vt[i].e;
      k = vt[i].kk;
      send_beat(vt[i].d, 1'b1);
      drain();
      chk("vec_count", 64'(oq0.size() - base), 64'd1);
      if (base < oq0.size()) begin
        chk("vec_wrap", 64'(oq0[base]), 64'(vt[i].x0));
        chk("vec_last", 64'(ol0[base]), 64'd1);
      end
      if (base < oq1.size())
        chk("vec_sat", 64'(oq1[base]), 64'(vt[i].x1));
      chk("vec_ovf_wrap", 64'(ovf0), 64'(vt[i].ov));
      chk("vec_ovf_sat", 64'(ovf1), 64'(vt[i].ov));
    end

    // Backpressure: two words held, data stable
    base = oq0.size();
    en = 1'b1;
    k = 8'd3;
    mready = 1'b0;
    seen = 0;
    held = '0;
    fork
      begin
        send_beat(32'd10, 1'b0);
        send_beat(32'd20, 1'b0);
        send_beat(32'd30, 1'b0);
        send_beat(32'd40, 1'b1);
      end
      begin
        repeat (5) begin
          @(negedge aclk);
          if (m0.tvalid) begin
            if (!seen) begin
              held = m0.tdata;
              seen = 1;
            end else begin
              chk("bp_stable", 64'(m0.tdata), 64'(held));
            end
          end
        end
        chk("bp_s_tready_low", 64'(s0.tready), 64'd0);
        chk("bp_held_first", 64'(held), 64'd30);
        @(posedge aclk);
        #1;
        mready = 1'b1;
      end
    join
    drain();
    chk_seq("bp", base, 32'd30, 32'd60, 32'd90, 32'd120, 4);

    // Asynchronous reset mid-frame
    en = 1'b1;
    k = 8'd9;
    send_beat(32'd5, 1'b0);
    send_beat(32'd6, 1'b0);
    @(posedge aclk);
    #2;
    chk("rst_pre_valid", 64'(m0.tvalid), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("arst_m_tvalid0", 64'(m0.tvalid), 64'd0);
    chk("arst_m_tvalid1", 64'(m1.tvalid), 64'd0);
    chk("arst_frame_cnt", 64'(fc0), 64'd0);
    chk("arst_ovf", 64'(ovf1), 64'd0);
    repeat (2) @(negedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    base = oq0.size();
    k = 8'd2;
    send_beat(32'd7, 1'b0);
    send_beat(32'd8, 1'b1);
    drain();
    chk_seq("arst", base, 32'd14, 32'd16, 32'd0, 32'd0, 2);
    chk("arst_frame_cnt_after", 64'(fc0), 64'd1);

    // Random traffic with random backpressure
    rdone = 0;
    fork
      begin
        for (int f = 0; f < 150; f++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            logic [31:0] d;
            if ($urandom_range(0, 3) == 0) begin
              @(posedge aclk);
              #1;
            end
            if ($urandom_range(0, 2) == 0) begin
              en = ($urandom_range(0, 3) != 0);
              case ($urandom_range(0, 3))
                0: k = 8'h00;
                1: k = 8'hFF;
                default: k = 8'($urandom);
              endcase
            end
            if ($urandom_range(0, 1) == 0) d = $urandom;
            else d = 32'($urandom_range(0, 1000));
            send_beat(d, b == len - 1);
          end
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge aclk);
          #1;
          mready = ($urandom_range(0, 3) != 0);
        end
        mready = 1'b1;
      end
    join
    drain();
    chk("rnd_frame_cnt0", 64'(fc0), 64'(16'(efr)));
    chk("rnd_frame_cnt1", 64'(fc1), 64'(16'(efr)));
    chk("rnd_ovf0", 64'(ovf0), 64'(eovf0));
    chk("rnd_ovf1", 64'(ovf1), 64'(eovf1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
